// File: rtl/pour_puzzle_if.sv
// Move-request / puzzle-state bundle for the cup-pouring puzzle.
// The master issues move requests; the slave (the puzzle) reports the
// cup levels, the goal flag, the move count and the reject pulse.
interface pour_puzzle_if #(
  parameter int NCUPS = 3,
  parameter int W     = 4,
  parameter int CW    = 8
);
  localparam int IW = ($clog2(NCUPS) > 1) ? $clog2(NCUPS) : 1;

  logic                 mv_valid;
  logic [IW-1:0]        from;
  logic [IW-1:0]        to;
  logic [NCUPS*W-1:0]   level;
  logic                 done;
  logic [CW-1:0]        moves;
  logic                 illegal;

  modport master (
    output mv_valid, from, to,
    input  level, done, moves, illegal
  );

  modport slave (
    input  mv_valid, from, to,
    output level, done, moves, illegal
  );
endinterface

// File: rtl/pour_puzzle.sv
// Cup-pouring puzzle: requests are registered first, then applied on the
// following edge.  A legal pour moves as much liquid as the source holds
// or the destination can still take, whichever is smaller.  Once the goal
// levels are reached the puzzle can optionally freeze.
module pour_puzzle #(
  parameter int                 NCUPS  = 3,
  parameter int                 W      = 4,
  parameter logic [NCUPS*W-1:0] CAPS   = 12'h58C,
  parameter logic [NCUPS*W-1:0] INIT   = 12'h00C,
  parameter logic [NCUPS*W-1:0] TARGET = 12'h066,
  parameter logic [NCUPS-1:0]   TMASK  = 3'b011,
  parameter bit                 LOCK   = 1'b1,
  parameter int                 CW     = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  pour_puzzle_if.slave bus
);
  localparam int IW = ($clog2(NCUPS) > 1) ? $clog2(NCUPS) : 1;

  logic [IW-1:0]      freg, treg;
  logic               vreg;
  logic [NCUPS*W-1:0] level_q, level_d;
  logic [CW-1:0]      moves_q;
  logic               illegal_q;
  logic               done_c, frozen, legal, f_ok, t_ok;
  logic [W-1:0]       src_lvl, dst_lvl, dst_cap, room, amt;

  // Move counter sticks at its maximum instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Request capture stage: only the registered copy feeds the update logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freg <= '0;
      treg <= '0;
      vreg <= 1'b0;
    end else begin
      freg <= bus.from;
      treg <= bus.to;
      vreg <= bus.mv_valid;
    end
  end

  // Goal check over the masked cups, straight from the current levels.
  always_comb begin
    done_c = 1'b1;
    for (int i = 0; i < NCUPS; i++) begin
      if (TMASK[i] && (level_q[i*W +: W] != TARGET[i*W +: W])) done_c = 1'b0;
    end
  end

  // Legality, pour amount and next levels for the registered request.
  always_comb begin
    src_lvl = '0;
    dst_lvl = '0;
    dst_cap = '0;
    for (int i = 0; i < NCUPS; i++) begin
      if (freg == IW'(i)) src_lvl = level_q[i*W +: W];
      if (treg == IW'(i)) begin
        dst_lvl = level_q[i*W +: W];
        dst_cap = CAPS[i*W +: W];
      end
    end
    f_ok   = ({1'b0, freg} < (IW+1)'(NCUPS));
    t_ok   = ({1'b0, treg} < (IW+1)'(NCUPS));
    frozen = LOCK && done_c;
    legal  = vreg && f_ok && t_ok && (freg != treg) && !frozen;
    room   = dst_cap - dst_lvl;
    amt    = (src_lvl < room) ? src_lvl : room;
    level_d = level_q;
    if (legal) begin
      for (int i = 0; i < NCUPS; i++) begin
        if (freg == IW'(i)) level_d[i*W +: W] = level_q[i*W +: W] - amt;
        if (treg == IW'(i)) level_d[i*W +: W] = level_q[i*W +: W] + amt;
      end
    end
  end

  // Apply stage: levels, move count and the one-cycle reject pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q   <= INIT;
      moves_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      if (legal) moves_q <= sat_inc(moves_q);
      illegal_q <= vreg && !frozen && !legal;
    end
  end

  assign bus.level   = level_q;
  assign bus.done    = done_c;
  assign bus.moves   = moves_q;
  assign bus.illegal = illegal_q;
endmodule

// File: doc/pour_puzzle.md
POUR_PUZZLE -- requirements
Module: pour_puzzle

Interface
REQ-001 Parameter NCUPS, default 3: number of cups, legal range 2..8.
REQ-002 Parameter W, default 4: width of each cup level in bits.
REQ-003 Parameter CAPS, default {5,8,12}: packed NCUPS*W capacities; cup i occupies bits [i*W +: W], so cup0=12, cup1=8, cup2=5.
REQ-004 Parameter INIT, default {0,0,12}: packed initial levels, same packing as CAPS.
REQ-005 Parameter TARGET, default {0,6,6}: packed goal levels, same packing as CAPS.
REQ-006 Parameter TMASK, default 3'b011: NCUPS-bit mask; bit i set means cup i is compared against TARGET.
REQ-007 Parameter LOCK, default 1: when 1, the puzzle freezes once done is asserted.
REQ-008 Parameter CW, default 8: move counter width.
REQ-009 Derived IW = max(1, clog2(NCUPS)).
REQ-010 clock  input  1  single clock, rising edge.
REQ-011 reset_n  input  1  asynchronous, active-low reset.
REQ-012 mv_valid  input  1  a move request is present this cycle.
REQ-013 from  input  IW  source cup index.
REQ-014 to  input  IW  destination cup index.
REQ-015 level  output  NCUPS*W  current cup levels, packed as CAPS.
REQ-016 done  output  1  goal reached.
REQ-017 moves  output  CW  count of applied legal moves.
REQ-018 illegal  output  1  one-cycle pulse when a rejected request is evaluated.

Function
REQ-019 Every rising edge SHALL latch from, to and mv_valid into freg, treg and vreg; only the latched copies drive the update logic.
REQ-020 A request sampled at edge k SHALL be reflected in level, moves and illegal after edge k+1 (two-stage latency); a new request SHALL be accepted every cycle with no backpressure.
REQ-021 A latched request SHALL be legal iff vreg=1, freg<NCUPS, treg<NCUPS and freg!=treg.
REQ-022 A legal move SHALL transfer amt = min(level[f], CAPS[t]-level[t]): the source is reduced by amt and the destination increased by amt, in the same edge.
REQ-023 A legal move with amt=0 (empty source or full destination) SHALL leave every level unchanged and SHALL still count as a move.
REQ-024 moves SHALL increment by 1 on each applied legal move and SHALL saturate at 2^CW-1.
REQ-025 A request with vreg=1 that is not legal SHALL leave level and moves unchanged and SHALL set illegal=1 for exactly that cycle.
REQ-026 With vreg=0, level and moves SHALL hold and illegal SHALL be 0.
REQ-027 done SHALL be combinational and equal to 1 iff level[i]==TARGET[i] for every i with TMASK[i]=1.
REQ-028 With LOCK=1 and done=1, latched requests SHALL be ignored: level and moves hold and illegal stays 0.
REQ-029 With LOCK=0, moves SHALL continue to apply after done, and done SHALL track the levels.
REQ-030 All arithmetic SHALL be W-bit unsigned; the sum of all levels SHALL equal the sum of INIT at all times.
REQ-031 The block SHALL NOT support parameter sets with INIT[i]>CAPS[i] or CAPS[i]>=2^W.

Reset
REQ-032 reset_n=0 SHALL immediately force level=INIT, freg=0, treg=0, vreg=0, moves=0 and illegal=0, independent of clock.
REQ-033 Reset asserted mid-operation SHALL discard any latched, unapplied request.
REQ-034 After reset_n rises, the first request SHALL be sampled at the first rising edge.

Verification
REQ-035 Release reset with mv_valid=0 for 4 cycles -> level={0,0,12}, moves=0, done=0, illegal=0 throughout.
REQ-036 Issue the moves 0->1, 1->2, 2->0, 1->2, 0->1, 1->2, 2->0 back-to-back -> levels step (4,8,0), (4,3,5), (9,3,0), (9,0,3), (1,8,3), (1,6,5), (6,6,0), each one cycle after the preceding one; done=1 and moves=7 after the last step.
REQ-037 From reset, request 1->1 then 0->3 -> illegal pulses on two consecutive cycles, level stays {0,0,12}, moves=0.
REQ-038 From reset, request 2->0 (empty source) -> level unchanged, moves=1, illegal=0.
REQ-039 After REQ-036, request 0->2 with LOCK=1 -> level stays (6,6,0), moves=7, done=1; repeat with LOCK=0 -> level (1,6,5), moves=8, done=0.
REQ-040 During REQ-036, assert reset_n low between edges with a move latched -> level={0,0,12} at once, moves=0, and the latched move is never applied after release.
